mdu_seq: RTL and testbench

Multi-cycle sequencer for the multiply/divide datapath. Accepts one MDU operation at a time from the CPU execute stage and launches it on the arithmetic datapath with a start/done handshake. Owns the architectural HI/LO registers and stalls the pipeline for new MDU ops and mfhi/mflo reads while an operation is in flight. It sits between the decode/execute control and the iterative multiplier/divider.

---
 rtl/mdu_seq_if.sv | 36 +++
 rtl/mdu_seq.sv | 133 +++++++++++++
 tb/tb_mdu_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Bundles the execute-stage MDU op/read port and the iterative datapath launch/done port.
// slave: the sequencer side; master: the CPU/datapath side that drives the sequencer.
interface mdu_seq_if #(
    parameter int DATA_W = 32
);
    logic              op_valid;
    logic [2:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              op_ready;
    logic              rd_req;
    logic              rd_sel;
    logic [DATA_W-1:0] rd_data;
    logic              rd_stall;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              dp_start;
    logic [2:0]        dp_op;
    logic [DATA_W-1:0] dp_a;
    logic [DATA_W-1:0] dp_b;
    logic              dp_done;
    logic [DATA_W-1:0] dp_hi;
    logic [DATA_W-1:0] dp_lo;
    logic              err;
    logic              div0;

    modport slave (
        input  op_valid, op, rs_val, rt_val, rd_req, rd_sel, dp_done, dp_hi, dp_lo,
        output op_ready, rd_data, rd_stall, hi, lo, dp_start, dp_op, dp_a, dp_b, err, div0
    );

    modport master (
        output op_valid, op, rs_val, rt_val, rd_req, rd_sel, dp_done, dp_hi, dp_lo,
        input  op_ready, rd_data, rd_stall, hi, lo, dp_start, dp_op, dp_a, dp_b, err, div0
    );
endinterface

// File: rtl/mdu_seq.sv
// MDU sequencer: owns HI/LO, launches mult/div on the iterative datapath and stalls reads meanwhile.
// Optional MDU_SEQ_DIV0_CHECK_EN resolves divide-by-zero locally instead of launching the datapath.
module mdu_seq #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    mdu_seq_if.slave    bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [DATA_W-1:0] cap_hi;
    logic [DATA_W-1:0] cap_lo;
    logic              err_r;

    logic accept;
    logic is_dp_op;
    logic is_div_op;
    logic div_zero;
    logic launch;

    assign accept    = (state == IDLE) && bus.op_valid;
    assign is_dp_op  = (bus.op >= 3'd1) && (bus.op <= 3'd4);
    assign is_div_op = (bus.op == 3'd3) || (bus.op == 3'd4);

`ifdef MDU_SEQ_DIV0_CHECK_EN
    assign div_zero = accept && is_div_op && (bus.rt_val == '0);
`else
    assign div_zero = 1'b0;
`endif
    assign launch = accept && is_dp_op && !div_zero;

    // Control state, architectural HI/LO and latched launch operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        op_r  <= bus.op;
                        a_r   <= bus.rs_val;
                        b_r   <= bus.rt_val;
                        state <= ISSUE;
                    end else if (div_zero) begin
                        hi_r <= bus.rs_val;
                        lo_r <= '1;
                    end else if (accept && bus.op == 3'd5) begin
                        hi_r <= bus.rs_val;
                    end else if (accept && bus.op == 3'd6) begin
                        lo_r <= bus.rs_val;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.dp_done) begin
                        state <= WRITE;
                    end else if (cnt == CNT_LAST) begin
                        err_r <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    hi_r  <= cap_hi;
                    lo_r  <= cap_lo;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result capture is pure data; it is only consumed after a WAIT-state done
    always_ff @(posedge clk) begin
        if (state == WAIT && bus.dp_done) begin
            cap_hi <= bus.dp_hi;
            cap_lo <= bus.dp_lo;
        end
    end

`ifdef MDU_SEQ_DIV0_CHECK_EN
    logic div0_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div0_r <= 1'b0;
        end else begin
            div0_r <= div_zero;
        end
    end

    assign bus.div0 = div0_r;
`else
    assign bus.div0 = 1'b0;
`endif

    assign bus.op_ready = (state == IDLE);
    assign bus.dp_start = (state == ISSUE);
    assign bus.dp_op    = op_r;
    assign bus.dp_a     = a_r;
    assign bus.dp_b     = b_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.err      = err_r;
    // Reads always see the architectural value; rd_stall tells execute whether it is current
    assign bus.rd_data  = bus.rd_sel ? hi_r : lo_r;
    assign bus.rd_stall = bus.rd_req && (state != IDLE);
endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: stimulus queues expected launches and HI/LO updates, a monitor checks them.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_seq_if bus ();

    mdu_seq #(.TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } launch_t;

    launch_t     launch_q[$];
    logic [63:0] res_q[$];
    int checks   = 0;
    int failures = 0;
    int div0_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one op for one accept edge; returns at the negedge after the accept
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.rs_val   = a;
        bus.rt_val   = b;
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    // From the ISSUE negedge: answer in WAIT cycle k, return at the IDLE negedge after WRITE
    task automatic run_wait(input int k, input logic [31:0] dh, input logic [31:0] dl,
                            output int low_rdy, output int stalls, output int starts);
        low_rdy = 0;
        stalls  = 0;
        starts  = 0;
        for (int i = 0; i < k + 3; i++) begin
            if (i > 0) @(negedge clk);
            if (i == k + 1) bus.dp_done = 1'b0;
            if (!bus.op_ready) low_rdy++;
            if (bus.rd_stall) stalls++;
            if (bus.dp_start) starts++;
            if (i == k) begin
                bus.dp_done = 1'b1;
                bus.dp_hi   = dh;
                bus.dp_lo   = dl;
            end
        end
    endtask

    initial begin : monitor
        logic [63:0] prev;
        logic [63:0] cur;
        logic [63:0] r;
        launch_t     l;
        @(negedge rst);
        prev = {bus.hi, bus.lo};
        forever begin
            @(negedge clk);
            if (bus.dp_start === 1'b1) begin
                if (launch_q.size() == 0) begin
                    chk("unexpected_dp_start", 32'(bus.dp_start), 32'd0);
                end else begin
                    l = launch_q.pop_front();
                    chk("dp_op", 32'(bus.dp_op), 32'(l.op));
                    chk("dp_a", bus.dp_a, l.a);
                    chk("dp_b", bus.dp_b, l.b);
                end
            end
            if (bus.div0 === 1'b1) div0_seen++;
            cur = {bus.hi, bus.lo};
            if (cur !== prev) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_hilo_hi", cur[63:32], prev[63:32]);
                    chk("unexpected_hilo_lo", cur[31:0], prev[31:0]);
                end else begin
                    r = res_q.pop_front();
                    chk("hilo_hi", cur[63:32], r[63:32]);
                    chk("hilo_lo", cur[31:0], r[31:0]);
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int low;
        int stalls;
        int starts;
        int exp_div0;
        bus.op_valid = 1'b0;
        bus.op       = 3'd0;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.rd_req   = 1'b0;
        bus.rd_sel   = 1'b0;
        bus.dp_done  = 1'b0;
        bus.dp_hi    = '0;
        bus.dp_lo    = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_dp_start", 32'(bus.dp_start), 32'd0);
        chk("rst_dp_op", 32'(bus.dp_op), 32'd0);
        chk("rst_dp_a", bus.dp_a, 32'd0);
        chk("rst_dp_b", bus.dp_b, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_div0", 32'(bus.div0), 32'd0);

        // mthi / mtlo
        res_q.push_back({32'h1234_5678, 32'h0});
        issue(3'd5, 32'h1234_5678, 32'h0);
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        bus.rd_req = 1'b1;
        bus.rd_sel = 1'b1;
        #1;
        chk("mthi_rd_data", bus.rd_data, 32'h1234_5678);
        chk("mthi_rd_stall", 32'(bus.rd_stall), 32'd0);
        bus.rd_req = 1'b0;
        res_q.push_back({32'h1234_5678, 32'h9ABC_DEF0});
        issue(3'd6, 32'h9ABC_DEF0, 32'h0);
        chk("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
        chk("mtlo_ready", 32'(bus.op_ready), 32'd1);

        // multu 0xFFFFFFFF x 2, done in the third WAIT cycle
        launch_q.push_back('{op: 3'd2, a: 32'hFFFF_FFFF, b: 32'd2});
        res_q.push_back({32'd1, 32'hFFFF_FFFE});
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_wait(3, 32'd1, 32'hFFFF_FFFE, low, stalls, starts);
        chk("multu_ready_low_cycles", 32'(low), 32'd5);
        chk("multu_start_pulses", 32'(starts), 32'd1);
        chk("multu_hi", bus.hi, 32'd1);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFE);

        // div -7/2 with rd_req held; read in the accept cycle sees pre-op LO
        launch_q.push_back('{op: 3'd3, a: 32'hFFFF_FFF9, b: 32'd2});
        res_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op       = 3'd3;
        bus.rs_val   = 32'hFFFF_FFF9;
        bus.rt_val   = 32'd2;
        bus.rd_req   = 1'b1;
        bus.rd_sel   = 1'b0;
        #1;
        chk("div_preop_rd_data", bus.rd_data, 32'hFFFF_FFFE);
        chk("div_preop_rd_stall", 32'(bus.rd_stall), 32'd0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        run_wait(1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, low, stalls, starts);
        chk("div_stall_cycles", 32'(stalls), 32'd3);
        chk("div_after_rd_stall", 32'(bus.rd_stall), 32'd0);
        chk("div_rd_data", bus.rd_data, 32'hFFFF_FFFD);
        bus.rd_sel = 1'b1;
        #1;
        chk("div_rd_hi", bus.rd_data, 32'hFFFF_FFFF);
        bus.rd_req = 1'b0;

        // timeout: no done at all
        launch_q.push_back('{op: 3'd1, a: 32'd3, b: 32'd4});
        issue(3'd1, 32'd3, 32'd4);
        repeat (64) @(negedge clk);
        chk("to_last_wait_ready", 32'(bus.op_ready), 32'd0);
        chk("to_last_wait_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("to_idle_ready", 32'(bus.op_ready), 32'd1);
        chk("to_err", 32'(bus.err), 32'd1);
        chk("to_hi", bus.hi, 32'hFFFF_FFFF);
        chk("to_lo", bus.lo, 32'hFFFF_FFFD);
        bus.dp_done = 1'b1;
        bus.dp_hi   = 32'hDEAD_BEEF;
        bus.dp_lo   = 32'hCAFE_F00D;
        @(negedge clk);
        bus.dp_done = 1'b0;
        @(negedge clk);
        chk("late_done_hi", bus.hi, 32'hFFFF_FFFF);
        chk("late_done_lo", bus.lo, 32'hFFFF_FFFD);
        chk("late_done_ready", 32'(bus.op_ready), 32'd1);

        // reset while in WAIT
        launch_q.push_back('{op: 3'd2, a: 32'd5, b: 32'd6});
        issue(3'd2, 32'd5, 32'd6);
        repeat (2) @(negedge clk);
        res_q.push_back(64'h0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus.op_ready), 32'd1);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        chk("midrst_err", 32'(bus.err), 32'd0);
        chk("midrst_dp_start", 32'(bus.dp_start), 32'd0);
        chk("midrst_dp_op", 32'(bus.dp_op), 32'd0);
        chk("midrst_dp_a", bus.dp_a, 32'd0);
        chk("midrst_dp_b", bus.dp_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.dp_done = 1'b1;
        bus.dp_hi   = 32'hAAAA_AAAA;
        bus.dp_lo   = 32'hBBBB_BBBB;
        @(negedge clk);
        bus.dp_done = 1'b0;
        chk("postrst_ready", 32'(bus.op_ready), 32'd1);
        chk("postrst_lo", bus.lo, 32'd0);
        launch_q.push_back('{op: 3'd2, a: 32'd7, b: 32'd3});
        res_q.push_back({32'd0, 32'd21});
        issue(3'd2, 32'd7, 32'd3);
        run_wait(1, 32'd0, 32'd21, low, stalls, starts);
        chk("postrst_starts", 32'(starts), 32'd1);
        chk("postrst_mul_lo", bus.lo, 32'd21);

        // divu 5/0
`ifdef MDU_SEQ_DIV0_CHECK_EN
        exp_div0 = 1;
        res_q.push_back({32'd5, 32'hFFFF_FFFF});
        issue(3'd4, 32'd5, 32'd0);
        chk("div0_ready", 32'(bus.op_ready), 32'd1);
        chk("div0_pulse", 32'(bus.div0), 32'd1);
        chk("div0_hi", bus.hi, 32'd5);
        chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("div0_pulse_end", 32'(bus.div0), 32'd0);
`else
        exp_div0 = 0;
        launch_q.push_back('{op: 3'd4, a: 32'd5, b: 32'd0});
        res_q.push_back({32'd5, 32'hFFFF_FFFF});
        issue(3'd4, 32'd5, 32'd0);
        run_wait(2, 32'd5, 32'hFFFF_FFFF, low, stalls, starts);
        chk("divz_starts", 32'(starts), 32'd1);
        chk("divz_hi", bus.hi, 32'd5);
        chk("divz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("divz_div0", 32'(bus.div0), 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("launch_q_drained", 32'(launch_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        chk("div0_pulse_count", 32'(div0_seen), 32'(exp_div0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
